// File: rtl/infra_rst_sequencer.sv
`default_nettype none
//============================================================================
// Module   : infra_rst_sequencer
// Brief    : Lock-qualified, staged reset release for board infrastructure.
// Revision : 1.0 - initial release
//============================================================================
module infra_rst_sequencer #(
   parameter int N_CH         = 4,
   parameter int HOLD_CYCLES  = 65535,
   parameter int STAGE_GAP    = 16,
   parameter int LOCK_FILTER  = 8,
   parameter int WAIT_IDELAY  = 1,
   parameter int IDLY_TIMEOUT = 4096
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            pll_lock,
   input  logic            idelay_rdy,
   output logic [N_CH-1:0] rst_out,
   output logic            all_ready,
   output logic            idly_err,
   output logic [15:0]     lock_lost_cnt,
   output logic [2:0]      seq_state
);

   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int IDLY_W = $clog2(IDLY_TIMEOUT + 1);
   localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [FILT_W-1:0] FILT_DONE = FILT_W'(LOCK_FILTER);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDLY_W-1:0] IDLY_LAST = IDLY_W'(IDLY_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      WAIT_IDLY = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   state_t            state;
   logic              lock_meta, lock_s, rdy_meta, rdy_s;
   logic [FILT_W-1:0] filt_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [IDLY_W-1:0] idly_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [CH_W-1:0]   ch_idx;

   assign seq_state = state;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         lock_meta     <= 1'b0;
         lock_s        <= 1'b0;
         rdy_meta      <= 1'b0;
         rdy_s         <= 1'b0;
         state         <= WAIT_LOCK;
         filt_cnt      <= '0;
         hold_cnt      <= '0;
         idly_cnt      <= '0;
         gap_cnt       <= '0;
         ch_idx        <= '0;
         rst_out       <= '1;
         all_ready     <= 1'b0;
         idly_err      <= 1'b0;
         lock_lost_cnt <= '0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
         rdy_meta  <= idelay_rdy;
         rdy_s     <= rdy_meta;

         // Losing lock anywhere past the filter overrides all progress.
         if (state != WAIT_LOCK && !lock_s) begin
            state     <= WAIT_LOCK;
            filt_cnt  <= '0;
            hold_cnt  <= '0;
            idly_cnt  <= '0;
            gap_cnt   <= '0;
            ch_idx    <= '0;
            rst_out   <= '1;
            all_ready <= 1'b0;
            if (lock_lost_cnt != 16'hFFFF)
               lock_lost_cnt <= lock_lost_cnt + 16'd1;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  if (!lock_s) begin
                     filt_cnt <= '0;
                  end else if (filt_cnt == FILT_LAST) begin
                     filt_cnt <= FILT_DONE;
                     hold_cnt <= '0;
                     state    <= HOLD;
                  end else begin
                     filt_cnt <= filt_cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (hold_cnt == HOLD_LAST) begin
                     idly_cnt <= '0;
                     gap_cnt  <= '0;
                     ch_idx   <= '0;
                     state    <= (WAIT_IDELAY != 0) ? WAIT_IDLY : RELEASE;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               WAIT_IDLY: begin
                  if (rdy_s) begin
                     state <= RELEASE;
                  end else if (idly_cnt == IDLY_LAST) begin
                     idly_err <= 1'b1;
                     state    <= RELEASE;
                  end else begin
                     idly_cnt <= idly_cnt + 1'b1;
                  end
               end
               RELEASE: begin
                  // gap_cnt counts down the spacing to the next channel release.
                  if (gap_cnt == '0) begin
                     rst_out[ch_idx] <= 1'b0;
                     if (ch_idx == CH_LAST) begin
                        all_ready <= 1'b1;
                        state     <= RUN;
                     end else begin
                        ch_idx  <= ch_idx + 1'b1;
                        gap_cnt <= GAP_LAST;
                     end
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
               RUN: begin
               end
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_infra_rst_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_infra_rst_sequencer
// Brief    : Directed self-checking bench for infra_rst_sequencer.
// Revision : 1.0 - initial release
//============================================================================
module tb_infra_rst_sequencer;

   logic       sys_clk = 1'b0;
   logic       rst_a = 1'b1, lock_a = 1'b0, rdy_a = 1'b0;
   logic       rst_b = 1'b1, lock_b = 1'b0, rdy_b = 1'b0;
   logic [2:0] rout_a, rout_b, st_a, st_b;
   logic       ready_a, ready_b, err_a, err_b;
   logic [15:0] lost_a, lost_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sys_clk = ~sys_clk;

   infra_rst_sequencer #(
      .N_CH(3), .HOLD_CYCLES(20), .STAGE_GAP(4), .LOCK_FILTER(3),
      .WAIT_IDELAY(0), .IDLY_TIMEOUT(10)
   ) dut_a (
      .sys_clk(sys_clk), .sys_rst(rst_a), .pll_lock(lock_a), .idelay_rdy(rdy_a),
      .rst_out(rout_a), .all_ready(ready_a), .idly_err(err_a),
      .lock_lost_cnt(lost_a), .seq_state(st_a)
   );

   infra_rst_sequencer #(
      .N_CH(3), .HOLD_CYCLES(20), .STAGE_GAP(4), .LOCK_FILTER(3),
      .WAIT_IDELAY(1), .IDLY_TIMEOUT(10)
   ) dut_b (
      .sys_clk(sys_clk), .sys_rst(rst_b), .pll_lock(lock_b), .idelay_rdy(rdy_b),
      .rst_out(rout_b), .all_ready(ready_b), .idly_err(err_b),
      .lock_lost_cnt(lost_b), .seq_state(st_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      tick(3);
      check("rst_rout", 32'(rout_a), 32'h7);
      check("rst_ready", 32'(ready_a), 32'h0);
      check("rst_err", 32'(err_a), 32'h0);
      check("rst_lost", 32'(lost_a), 32'h0);
      check("rst_state", 32'(st_a), 32'h0);
      rst_a = 1'b0;
      tick(1);

      // Two-cycle lock glitch must not qualify.
      lock_a = 1'b1;
      tick(2);
      lock_a = 1'b0;
      tick(8);
      check("glitch_state", 32'(st_a), 32'h0);
      check("glitch_lost", 32'(lost_a), 32'h0);

      // Clean lock: t0 is the next edge.
      lock_a = 1'b1;
      tick(4);
      check("t1_filt_t3", 32'(st_a), 32'h0);
      tick(1);
      check("t1_hold_t4", 32'(st_a), 32'h1);
      tick(19);
      check("t1_hold_t23", 32'(st_a), 32'h1);
      tick(1);
      check("t1_rel_t24", 32'(st_a), 32'h3);
      check("t1_rout_t24", 32'(rout_a), 32'h7);
      tick(1);
      check("t1_rout_t25", 32'(rout_a), 32'h6);
      tick(3);
      check("t1_rout_t28", 32'(rout_a), 32'h6);
      tick(1);
      check("t1_rout_t29", 32'(rout_a), 32'h4);
      tick(3);
      check("t1_rout_t32", 32'(rout_a), 32'h4);
      check("t1_ready_t32", 32'(ready_a), 32'h0);
      tick(1);
      check("t1_rout_t33", 32'(rout_a), 32'h0);
      check("t1_ready_t33", 32'(ready_a), 32'h1);
      check("t1_run_t33", 32'(st_a), 32'h4);

      // One-cycle lock drop in RUN; relock edge is a+1.
      tick(5);
      lock_a = 1'b0;
      tick(1);
      lock_a = 1'b1;
      tick(1);
      check("t2_rout_a1", 32'(rout_a), 32'h0);
      tick(1);
      check("t2_rout_a2", 32'(rout_a), 32'h7);
      check("t2_ready_a2", 32'(ready_a), 32'h0);
      check("t2_lost_a2", 32'(lost_a), 32'h1);
      check("t2_state_a2", 32'(st_a), 32'h0);
      tick(23);
      check("t2_rout_a25", 32'(rout_a), 32'h7);
      tick(1);
      check("t2_rout_a26", 32'(rout_a), 32'h6);
      tick(8);
      check("t2_rout_a34", 32'(rout_a), 32'h0);
      check("t2_ready_a34", 32'(ready_a), 32'h1);

      // sys_rst in the middle of the release staircase.
      tick(3);
      lock_a = 1'b0;
      tick(1);
      lock_a = 1'b1;
      tick(30);
      check("t5_rout_mid", 32'(rout_a), 32'h4);
      check("t5_lost_mid", 32'(lost_a), 32'h2);
      rst_a = 1'b1;
      tick(1);
      check("t5_rout", 32'(rout_a), 32'h7);
      check("t5_state", 32'(st_a), 32'h0);
      check("t5_lost", 32'(lost_a), 32'h0);
      check("t5_ready", 32'(ready_a), 32'h0);
      rst_a = 1'b0;

      // Saturation of the loss counter.
      tick(10);
      check("t6_in_hold", 32'(st_a), 32'h1);
      force dut_a.lock_lost_cnt = 16'hFFFF;
      tick(1);
      release dut_a.lock_lost_cnt;
      lock_a = 1'b0;
      tick(3);
      check("t6_state", 32'(st_a), 32'h0);
      check("t6_lost_sat", 32'(lost_a), 32'hFFFF);
      lock_a = 1'b1;

      // IDELAYCTRL never ready: timeout after 10 cycles in WAIT_IDLY.
      rst_b = 1'b0;
      tick(1);
      lock_b = 1'b1;
      tick(25);
      check("t4_idly_entry", 32'(st_b), 32'h2);
      tick(9);
      check("t4_idly_e9", 32'(st_b), 32'h2);
      check("t4_err_e9", 32'(err_b), 32'h0);
      tick(1);
      check("t4_rel_e10", 32'(st_b), 32'h3);
      check("t4_err_e10", 32'(err_b), 32'h1);
      check("t4_rout_e10", 32'(rout_b), 32'h7);
      tick(1);
      check("t4_rout_e11", 32'(rout_b), 32'h6);

      // Rerun with idelay_rdy rising mid-wait.
      rst_b = 1'b1;
      tick(1);
      check("t4b_err_rst", 32'(err_b), 32'h0);
      rst_b = 1'b0;
      tick(25);
      check("t4b_idly_entry", 32'(st_b), 32'h2);
      tick(3);
      rdy_b = 1'b1;
      tick(2);
      check("t4b_wait_r1", 32'(st_b), 32'h2);
      tick(1);
      check("t4b_rel_r2", 32'(st_b), 32'h3);
      check("t4b_err_r2", 32'(err_b), 32'h0);
      tick(1);
      check("t4b_rout_r3", 32'(rout_b), 32'h6);
      tick(8);
      check("t4b_ready", 32'(ready_b), 32'h1);
      rdy_b = 1'b0;
      tick(5);
      check("t4b_run_hold", 32'(st_b), 32'h4);
      check("t4b_ready_hold", 32'(ready_b), 32'h1);
      check("t4b_err_hold", 32'(err_b), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
